// File: rtl/md_engine.sv
// md_engine: multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// An accepted MULT/MULTU/DIV/DIVU computes its result into pending registers
// straight away. The unit then stays busy for MUL_LAT or DIV_LAT cycles and
// copies the result into HI/LO on the last busy edge. HI and LO therefore never
// show a result before the op retires. MTHI/MTLO write HI/LO directly, without
// going busy.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   start  in   request to issue op this cycle
//   op     in   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6/7 ignored)
//   src_a  in   rs operand (multiplicand / dividend / MTHI-MTLO data)
//   src_b  in   rt operand (multiplier / divisor)
//   abort  in   cancels in-flight work; also blocks acceptance that cycle
//   busy   out  operation in flight
//   done   out  one-cycle retire pulse
//   dz     out  divide-by-zero flag, qualified by done
//   hi/lo  out  HI/LO registers
module md_engine #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_pend_hi, r_pend_lo;
  logic               r_pend_dz;
  logic               w_accept, w_arith, w_last;
  logic [2*WIDTH-1:0] w_prod, w_divres;

  // Sign-extend (or zero-extend) both operands to 2*WIDTH. A plain modular
  // multiply of the extended values then gives the correct full-width product
  // for both the signed and the unsigned case.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    logic [2*WIDTH-1:0] ea, eb;
    ea = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    eb = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    return ea * eb;
  endfunction

  // The divide works on magnitudes and fixes the signs afterwards, so there is
  // no signed-overflow corner case. For most-negative / -1 the magnitude
  // quotient is 2^(WIDTH-1) and no negation follows, so the result is
  // most-negative with remainder 0. Returns {remainder, quotient}.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    logic             na, nb;
    logic [WIDTH-1:0] ma, mb, q, r;
    na = sgn & a[WIDTH-1];
    nb = sgn & b[WIDTH-1];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    if (mb == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    return {(na ? -r : r), ((na ^ nb) ? -q : q)};
  endfunction

  assign w_accept = start & (r_state == S_IDLE) & ~abort & (op <= 3'd5);
  assign w_arith  = w_accept & (op <= 3'd3);
  assign w_last   = (r_state == S_RUN) & ~abort & (r_cnt == CNT_W'(1));
  // op[0] selects the unsigned variant for both multiply and divide.
  assign w_prod   = mul_full(src_a, src_b, ~op[0]);
  assign w_divres = div_full(src_a, src_b, ~op[0]);
  assign busy     = (r_state == S_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_arith) w_state_nxt = S_RUN;
      S_RUN:  if (abort || r_cnt == CNT_W'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_dz <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      if (w_accept) begin
        case (op)
          3'd0, 3'd1: begin
            {r_pend_hi, r_pend_lo} <= w_prod;
            r_pend_dz              <= 1'b0;
            r_cnt                  <= CNT_W'(MUL_LAT);
          end
          3'd2, 3'd3: begin
            {r_pend_hi, r_pend_lo} <= w_divres;
            r_pend_dz              <= (src_b == '0);
            r_cnt                  <= CNT_W'(DIV_LAT);
          end
          3'd4: begin
            hi   <= src_a;
            done <= 1'b1;
          end
          3'd5: begin
            lo   <= src_a;
            done <= 1'b1;
          end
          default: ;
        endcase
      end else if (r_state == S_RUN) begin
        // Abort takes priority over retirement, even on the final busy edge.
        if (abort) begin
          r_cnt <= '0;
        end else if (w_last) begin
          r_cnt <= '0;
          done  <= 1'b1;
          dz    <= r_pend_dz;
          if (!r_pend_dz) begin
            hi <= r_pend_hi;
            lo <= r_pend_lo;
          end
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_md_engine.sv
module tb_md_engine;
  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_engine #(.WIDTH(32), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .abort(abort), .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
  // Returns {dz, hi, lo}.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] h, input logic [31:0] l);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin p = sa * sb; return {1'b0, p}; end
      3'd1: begin up = ua * ub; return {1'b0, up}; end
      3'd2: begin
        if (b == 32'd0) return {1'b1, h, l};
        q = sa / sb; r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, h, l};
        uq = ua / ub; ur = ua % ub;
        return {1'b0, ur[31:0], uq[31:0]};
      end
      3'd4: return {1'b0, a, l};
      3'd5: return {1'b0, h, a};
      default: return {1'b0, h, l};
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one request for one edge; returns one time unit after that edge.
  task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts the cycles that busy is high, bounded by limit.
  task automatic wait_retire(input int limit, output int n);
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if ({busy, done, dz} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, dz}); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    step(); step();
    reset = 1'b1;
    step();
    total++; if ({busy, done, dz, hi, lo} !== 67'd0) begin bad++; $display("FAIL reset_release got=%b %h %h", {busy, done, dz}, hi, lo); end
  endtask

  task automatic test_mult();
    int n;
    drive_start(3'd0, 32'hFFFFFFFE, 32'd3);
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL mult_early got=%h_%h want=0_0", hi, lo); end
    wait_retire(40, n);
    total++; if (n !== ML) begin bad++; $display("FAIL mult_busy got=%0d want=%0d", n, ML); end
    total++; if ({done, dz} !== 2'b10) begin bad++; $display("FAIL mult_done got=%b want=10", {done, dz}); end
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_res got=%h_%h want=ffffffff_fffffffa", hi, lo); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_pulse got=%b want=0", done); end
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFA;
  endtask

  task automatic test_divz();
    int n;
    drive_start(3'd4, 32'h11, 32'd0);
    total++; if ({busy, done, dz, hi} !== {3'b010, 32'h11}) begin bad++; $display("FAIL mthi got=%b %h want=010 11", {busy, done, dz}, hi); end
    drive_start(3'd5, 32'h22, 32'd0);
    total++; if ({busy, done, dz, lo} !== {3'b010, 32'h22}) begin bad++; $display("FAIL mtlo got=%b %h want=010 22", {busy, done, dz}, lo); end
    drive_start(3'd3, 32'd7, 32'd0);
    wait_retire(40, n);
    total++; if (n !== DL) begin bad++; $display("FAIL divz_busy got=%0d want=%0d", n, DL); end
    total++; if ({done, dz} !== 2'b11) begin bad++; $display("FAIL divz_flags got=%b want=11", {done, dz}); end
    total++; if (hi !== 32'h11 || lo !== 32'h22) begin bad++; $display("FAIL divz_keep got=%h_%h want=11_22", hi, lo); end
    m_hi = 32'h11; m_lo = 32'h22;
  endtask

  task automatic test_div();
    int n;
    drive_start(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_retire(40, n);
    total++; if ({n, done, dz} !== {DL, 2'b10}) begin bad++; $display("FAIL div_neg_ctl got=%0d %b want=%0d 10", n, {done, dz}, DL); end
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg got=%h_%h want=ffffffff_fffffffd", hi, lo); end
    drive_start(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_retire(40, n);
    total++; if ({done, dz} !== 2'b10) begin bad++; $display("FAIL div_ovf_flags got=%b want=10", {done, dz}); end
    total++; if (hi !== 32'd0 || lo !== 32'h80000000) begin bad++; $display("FAIL div_ovf got=%h_%h want=0_80000000", hi, lo); end
    m_hi = 32'd0; m_lo = 32'h80000000;
  endtask

  task automatic test_abort();
    drive_start(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_ctl got=%b want=00", {busy, done}); end
    total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL abort_keep got=%h_%h want=%h_%h", hi, lo, m_hi, m_lo); end
    step();
    total++; if (done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL abort_late got=%b %h_%h", done, hi, lo); end
  endtask

  task automatic test_ignored();
    int n;
    drive_start(3'd0, 32'd3, 32'd4);
    op = 3'd5; src_a = 32'hDEAD; start = 1'b1;
    step();
    start = 1'b0;
    total++; if (lo !== m_lo) begin bad++; $display("FAIL busy_start_lo got=%h want=%h", lo, m_lo); end
    wait_retire(40, n);
    total++; if (n + 1 !== ML) begin bad++; $display("FAIL busy_start_len got=%0d want=%0d", n + 1, ML); end
    total++; if (hi !== 32'd0 || lo !== 32'd12) begin bad++; $display("FAIL busy_start_res got=%h_%h want=0_c", hi, lo); end
    m_hi = 32'd0; m_lo = 32'd12;
    drive_start(3'd6, 32'h1234, 32'd5);
    total++; if ({busy, done, hi, lo} !== {2'b00, m_hi, m_lo}) begin bad++; $display("FAIL op6 got=%b %h_%h", {busy, done}, hi, lo); end
    drive_start(3'd7, 32'h5678, 32'd1);
    total++; if ({busy, done, hi, lo} !== {2'b00, m_hi, m_lo}) begin bad++; $display("FAIL op7 got=%b %h_%h", {busy, done}, hi, lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    drive_start(3'd1, 32'h10000, 32'h10000);
    wait_retire(40, n);
    total++; if ({done, hi, lo} !== {1'b1, 32'd1, 32'd0}) begin bad++; $display("FAIL b2b_first got=%b %h_%h want=1 1_0", done, hi, lo); end
    drive_start(3'd3, 32'd100, 32'd7);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    wait_retire(40, n);
    total++; if ({n, done, hi, lo} !== {DL, 1'b1, 32'd2, 32'd14}) begin bad++; $display("FAIL b2b_second got=%0d %b %h_%h", n, done, hi, lo); end
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [64:0] e;
    int n, lat, k, r;
    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      if (r == 1) b = 32'hFFFFFFFF;
      if (r == 2) a = 32'h80000000;
      if (r == 3) b = 32'($urandom_range(1, 9));
      e = model(o, a, b, m_hi, m_lo);
      drive_start(o, a, b);
      if (o >= 3'd6) begin
        total++; if ({busy, done, hi, lo} !== {2'b00, m_hi, m_lo}) begin bad++; $display("FAIL rnd_ign i=%0d got=%b %h_%h", i, {busy, done}, hi, lo); end
      end else if (o >= 3'd4) begin
        total++; if ({busy, done, dz, hi, lo} !== {3'b010, e[63:0]}) begin bad++; $display("FAIL rnd_mt i=%0d got=%b %h_%h want=%h", i, {busy, done, dz}, hi, lo, e[63:0]); end
        m_hi = e[63:32]; m_lo = e[31:0];
      end else begin
        lat = (o < 3'd2) ? ML : DL;
        if ($urandom_range(0, 3) == 0) begin
          k = $urandom_range(1, lat);
          for (int j = 1; j < k; j++) step();
          abort = 1'b1;
          step();
          abort = 1'b0;
          total++; if ({busy, done, hi, lo} !== {2'b00, m_hi, m_lo}) begin bad++; $display("FAIL rnd_abort i=%0d k=%0d got=%b %h_%h", i, k, {busy, done}, hi, lo); end
        end else begin
          wait_retire(40, n);
          total++; if ({n, done, dz, hi, lo} !== {lat, 1'b1, e}) begin bad++; $display("FAIL rnd_op i=%0d op=%0d a=%h b=%h got=%0d %b %h_%h want=%0d %h", i, o, a, b, n, {done, dz}, hi, lo, lat, e); end
          m_hi = e[63:32]; m_lo = e[31:0];
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    drive_start(3'd2, 32'd100, 32'd3);
    step(); step(); step();
    #2 reset = 1'b0;
    #1;
    total++; if ({busy, done, dz, hi, lo} !== 67'd0) begin bad++; $display("FAIL rst_mid got=%b %h_%h want=000 0_0", {busy, done, dz}, hi, lo); end
    step();
    reset = 1'b1;
    drive_start(3'd5, 32'h5, 32'd0);
    total++; if ({busy, done, hi, lo} !== {2'b01, 32'd0, 32'd5}) begin bad++; $display("FAIL rst_mtlo got=%b %h_%h want=01 0_5", {busy, done}, hi, lo); end
    m_hi = 32'd0; m_lo = 32'd5;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divz();
    test_div();
    test_abort();
    test_ignored();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
